// File: rtl/apb_pkg.sv
// Shared APB types and constants for the requester, the slave and the bench.
package apb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    // Highest address the zero-wait slave accepts; anything above returns pslverr.
    localparam int unsigned SLV_ADDR_LIMIT = 200;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

endpackage : apb_pkg

// File: rtl/apb_requester_if.sv
// Command, response and APB bus signals of the requester bundled together.
interface apb_requester_if #(
    parameter int unsigned ADDR_W = apb_pkg::ADDR_W,
    parameter int unsigned DATA_W = apb_pkg::DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_tmo;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // Requester side: drives the APB bus and the response channel.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output psel, penable, pwrite, paddr, pwdata
    );

    // Environment side: command source, response sink and APB slave.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface : apb_requester_if

// File: rtl/apb_requester.sv
// Single-outstanding APB requester with a wait-state timeout.
// One command at a time: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = apb_pkg::ADDR_W,
    parameter int unsigned DATA_W  = apb_pkg::DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             pclk,
    input  logic             prst,
    apb_requester_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    apb_req_state_e    state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_tmo_q, rsp_tmo_d;

    // State and registered bus/response outputs; reset forces the bus idle at once.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = SETUP;
                    count_d   = '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.cmd_write;
                    paddr_d   = bus.cmd_addr;
                    // Reads present a clean zero on pwdata.
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_tmo_d   = 1'b0;
                    rsp_rdata_d = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
                end else if (count_q == CNT_W'(TIMEOUT - 1)) begin
                    // Slave hung: abandon the transfer with an error completion.
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    count_d = CNT_W'(count_q + 1'b1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command acceptance is only possible from IDLE.
    assign bus.cmd_ready = (state_q == IDLE);

    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_tmo   = rsp_tmo_q;

endmodule : apb_requester

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed scenarios then random transfers against a
// transaction-level model (memory image + expected response/latency per command).
module tb_apb_requester;
    import apb_pkg::*;

    localparam int unsigned TMO = 4;

    logic pclk;
    logic prst;
    logic hang;
    logic slv_clear;
    logic [7:0] slv_mem [256];
    logic [7:0] model_mem [256];

    int n_cmp;
    int n_bad;

    apb_requester_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus.master)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Zero-wait slave, or a stuck one while hang is set.
    assign bus.pready  = !hang;
    assign bus.pslverr = (bus.paddr > 8'(SLV_ADDR_LIMIT));
    assign bus.prdata  = slv_mem[bus.paddr];

    always @(posedge pclk) begin
        if (slv_clear) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= 8'h00;
        end else if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr) begin
            slv_mem[bus.paddr] <= bus.pwdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One command through the requester; expectations come from the memory image.
    task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                           input logic hang_i, input int delay);
        logic       exp_err;
        logic       exp_tmo;
        logic [7:0] exp_rd;
        int         acc;
        int         cyc;
        exp_tmo = hang_i;
        exp_err = hang_i || (addr > 8'(SLV_ADDR_LIMIT));
        exp_rd  = (wr || exp_err) ? 8'h00 : model_mem[addr];
        acc     = hang_i ? int'(TMO) : 1;

        @(negedge pclk);
        hang          = hang_i;
        bus.rsp_ready = (delay == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);

        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = 8'($urandom);
        cyc = 1;
        while (bus.rsp_valid !== 1'b1 && cyc < 64) begin
            check("psel_xfer", 32'(bus.psel), 32'd1);
            check("penable_xfer", 32'(bus.penable), (cyc == 1) ? 32'd0 : 32'd1);
            check("paddr_xfer", 32'(bus.paddr), 32'(addr));
            check("pwrite_xfer", 32'(bus.pwrite), 32'(wr));
            check("pwdata_xfer", 32'(bus.pwdata), wr ? 32'(wd) : 32'd0);
            check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
            @(posedge pclk);
            #1;
            cyc++;
        end
        check("rsp_latency", 32'(cyc), 32'(2 + acc));
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("psel_resp", 32'(bus.psel), 32'd0);
        check("penable_resp", 32'(bus.penable), 32'd0);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_tmo", 32'(bus.rsp_tmo), 32'(exp_tmo));
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        check("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);

        // Consumer stalls: response must hold and no new command may start.
        for (int i = 0; i < delay; i++) begin
            if (i == 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'b1;
                bus.cmd_addr  = 8'h01;
                bus.cmd_wdata = 8'h5A;
            end
            @(posedge pclk);
            #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
            check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
            check("hold_psel", 32'(bus.psel), 32'd0);
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        @(posedge pclk);
        #1;
        check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        check("psel_idle", 32'(bus.psel), 32'd0);
        hang = 1'b0;
        if (wr && !exp_err) model_mem[addr] = wd;
    endtask

    initial begin
        logic       wr;
        logic       hg;
        logic [7:0] addr;
        n_cmp = 0;
        n_bad = 0;
        hang = 1'b0;
        slv_clear = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        prst = 1'b1;
        #1 prst = 1'b0;
        #1;
        check("rst_psel", 32'(bus.psel), 32'd0);
        check("rst_penable", 32'(bus.penable), 32'd0);
        check("rst_pwrite", 32'(bus.pwrite), 32'd0);
        check("rst_paddr", 32'(bus.paddr), 32'd0);
        check("rst_pwdata", 32'(bus.pwdata), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_tmo", 32'(bus.rsp_tmo), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        slv_clear = 1'b0;
        prst = 1'b1;

        // Directed scenarios.
        do_xfer(1'b1, 8'h05, 8'hA5, 1'b0, 0);
        do_xfer(1'b0, 8'h05, 8'h00, 1'b0, 0);
        do_xfer(1'b1, 8'hD2, 8'h77, 1'b0, 0);
        do_xfer(1'b0, 8'hD2, 8'h00, 1'b0, 0);
        do_xfer(1'b1, 8'hC8, 8'h3C, 1'b0, 0);
        do_xfer(1'b0, 8'hC8, 8'h00, 1'b0, 0);
        do_xfer(1'b0, 8'h05, 8'h00, 1'b1, 0);
        do_xfer(1'b1, 8'h06, 8'h99, 1'b1, 0);
        do_xfer(1'b0, 8'h05, 8'h00, 1'b0, 5);

        // Reset while stuck in ACCESS: bus idles immediately, no response.
        @(negedge pclk);
        hang = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h09;
        bus.cmd_wdata = 8'hEE;
        @(posedge pclk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge pclk);
        #1;
        check("pre_rst_penable", 32'(bus.penable), 32'd1);
        #2 prst = 1'b0;
        #1;
        check("mid_rst_psel", 32'(bus.psel), 32'd0);
        check("mid_rst_penable", 32'(bus.penable), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) begin
            @(posedge pclk);
            #1;
            check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge pclk);
        hang = 1'b0;
        prst = 1'b1;
        do_xfer(1'b0, 8'h09, 8'h00, 1'b0, 0);
        do_xfer(1'b1, 8'h09, 8'h42, 1'b0, 1);
        do_xfer(1'b0, 8'h09, 8'h00, 1'b0, 0);

        // Random traffic over a small window plus the error region.
        for (int n = 0; n < 60; n++) begin
            wr   = 1'($urandom);
            hg   = ($urandom_range(0, 7) == 0);
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(195, 215))
                                               : 8'($urandom_range(0, 15));
            do_xfer(wr, addr, 8'($urandom), hg, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_apb_requester
